alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// Three-state (IDLE/EXEC/WB) instruction controller driving an external ALU and register file.
// Define ALU_CTRL_ILLEGAL_EN to add the sticky `illegal` output for undecoded instructions.
module alu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  rf_addr_a,
  output logic [3:0]  rf_addr_b,
  input  logic [15:0] rf_data_a,
  input  logic [15:0] rf_data_b,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_dst,
  output logic [15:0] alu_src,
  input  logic [15:0] alu_result,
  input  logic        alu_c,
  input  logic        alu_l,
  input  logic        alu_f,
  input  logic        alu_z,
  input  logic        alu_n,
  output logic        rf_we,
  output logic [3:0]  rf_wr_addr,
  output logic [15:0] rf_wr_data,
  output logic [4:0]  psr,
  output logic        busy
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;
  typedef enum logic [2:0] {DecAdd, DecSub, DecCmp, DecAnd, DecOr, DecXor, DecMov, DecNop} dec_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;  // {N,Z,F,L,C} captured in EXEC
  logic [4:0]  psr_q, psr_d;

  logic        is_imm;
  logic [3:0]  code;
  dec_e        dec;
  logic        sext;
  logic        wb_en;
  logic [15:0] imm_ext;

  // Immediate forms reuse the R-type ext encoding in the op field.
  always_comb begin
    is_imm = (instr_q[15:12] != 4'h0);
    code   = is_imm ? instr_q[15:12] : instr_q[7:4];
    case (code)
      4'h5:    dec = DecAdd;
      4'h9:    dec = DecSub;
      4'hB:    dec = DecCmp;
      4'h1:    dec = DecAnd;
      4'h2:    dec = DecOr;
      4'h3:    dec = DecXor;
      4'hD:    dec = DecMov;
      default: dec = DecNop;
    endcase
  end

  assign sext    = (dec == DecAdd) || (dec == DecSub) || (dec == DecCmp);
  assign wb_en   = (dec != DecCmp) && (dec != DecNop);
  assign imm_ext = sext ? {{8{instr_q[7]}}, instr_q[7:0]} : {8'h00, instr_q[7:0]};

  assign rf_addr_a = instr_q[11:8];
  assign rf_addr_b = instr_q[3:0];

  always_comb begin
    alu_op  = 3'b000;
    alu_dst = rf_data_a;
    alu_src = is_imm ? imm_ext : rf_data_b;
    case (dec)
      DecSub, DecCmp: alu_op = 3'b100;
      DecAnd:         alu_op = 3'b001;
      DecOr:          alu_op = 3'b010;
      DecXor:         alu_op = 3'b011;
      DecMov: begin
        alu_op  = 3'b010;
        alu_dst = 16'h0000;
      end
      default: ;
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    flags_d  = flags_q;
    psr_d    = psr_q;
`ifdef ALU_CTRL_ILLEGAL_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        flags_d  = {alu_n, alu_z, alu_f, alu_l, alu_c};
        state_d  = StWb;
      end
      StWb: begin
        if (dec == DecAdd || dec == DecSub) begin
          psr_d[2] = flags_q[2];
          psr_d[0] = flags_q[0];
        end else if (dec == DecCmp) begin
          psr_d[4] = flags_q[4];
          psr_d[3] = flags_q[3];
          psr_d[1] = flags_q[1];
        end
`ifdef ALU_CTRL_ILLEGAL_EN
        if (dec == DecNop) illegal_d = 1'b1;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      instr_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
      psr_q    <= '0;
`ifdef ALU_CTRL_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      psr_q    <= psr_d;
`ifdef ALU_CTRL_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  // Gated by reset so an abort in WB never produces a write.
  assign rf_we       = (state_q == StWb) && wb_en && !reset;
  assign rf_wr_addr  = instr_q[11:8];
  assign rf_wr_data  = result_q;
  assign psr         = psr_q;
`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal     = illegal_q;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: register file + ALU environment, instruction-level model,
// per-cycle comparison and hand-computed literal expectations.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_data_a, rf_data_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_dst, alu_src, alu_result;
  logic        alu_c, alu_l, alu_f, alu_z, alu_n;
  logic        rf_we;
  logic [3:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [4:0]  psr;
  logic        busy;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .rf_addr_a  (rf_addr_a),
    .rf_addr_b  (rf_addr_b),
    .rf_data_a  (rf_data_a),
    .rf_data_b  (rf_data_b),
    .alu_op     (alu_op),
    .alu_dst    (alu_dst),
    .alu_src    (alu_src),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_l      (alu_l),
    .alu_f      (alu_f),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .rf_we      (rf_we),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .psr        (psr),
    .busy       (busy)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal    (illegal)
`endif
  );

  // Environment: register file with a bench poke port, and a combinational ALU.
  logic        poke_en = 1'b0;
  logic [3:0]  poke_addr = 4'h0;
  logic [15:0] poke_data = 16'h0;
  logic [15:0] rf [16] = '{default: 16'h0};

  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  always @(posedge clk) begin
    if (rf_we) rf[rf_wr_addr] <= rf_wr_data;
    else if (poke_en) rf[poke_addr] <= poke_data;
  end

  int sres;
  always_comb begin
    sres       = 0;
    alu_result = 16'h0;
    case (alu_op[1:0])
      2'b00: begin
        alu_result = alu_op[2] ? alu_dst - alu_src : alu_dst + alu_src;
        sres = alu_op[2] ? int'($signed(alu_dst)) - int'($signed(alu_src))
                         : int'($signed(alu_dst)) + int'($signed(alu_src));
      end
      2'b01:   alu_result = alu_dst & alu_src;
      2'b10:   alu_result = alu_dst | alu_src;
      default: alu_result = alu_dst ^ alu_src;
    endcase
    alu_c = alu_op[2] ? (alu_dst < alu_src) : ((32'(alu_dst) + 32'(alu_src)) > 32'h0000_FFFF);
    alu_f = (sres > 32767) || (sres < -32768);
    alu_l = alu_dst < alu_src;
    alu_n = $signed(alu_dst) < $signed(alu_src);
    alu_z = (alu_result == 16'h0);
  end

  // Instruction-level model: phase 0 idle, 1 execute, 2 write-back.
  int          m_phase = 0;
  logic [15:0] m_instr = 16'h0;
  logic [15:0] m_regs [16] = '{default: 16'h0};
  logic [4:0]  m_psr = 5'h0;
  logic        m_exp_we = 1'b0;
  logic [15:0] m_exp_res = 16'h0;
  logic [4:0]  m_exp_psr = 5'h0;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic        m_illegal = 1'b0;

  function automatic logic undecoded(input logic [15:0] i);
    logic [3:0] c;
    c = (i[15:12] != 4'h0) ? i[15:12] : i[7:4];
    return !(c inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD});
  endfunction
`endif

  // psr layout {N,Z,F,L,C}
  function automatic void model_exec(input logic [15:0] i, output logic we,
                                     output logic [15:0] res, output logic [4:0] p);
    logic [3:0]  code;
    logic [15:0] a, b;
    logic [16:0] w;
    logic        imm;
    imm  = (i[15:12] != 4'h0);
    code = imm ? i[15:12] : i[7:4];
    a    = m_regs[i[11:8]];
    if (!imm) b = m_regs[i[3:0]];
    else if (code == 4'h5 || code == 4'h9 || code == 4'hB) b = {{8{i[7]}}, i[7:0]};
    else b = {8'h00, i[7:0]};
    we  = 1'b1;
    res = a;
    p   = m_psr;
    w   = 17'h0;
    case (code)
      4'h5: begin
        w    = {1'b0, a} + {1'b0, b};
        res  = w[15:0];
        p[0] = w[16];
        p[2] = (a[15] == b[15]) && (res[15] != a[15]);
      end
      4'h9: begin
        res  = a - b;
        p[0] = a < b;
        p[2] = (a[15] != b[15]) && (res[15] != a[15]);
      end
      4'hB: begin
        we   = 1'b0;
        p[4] = $signed(a) < $signed(b);
        p[3] = (a == b);
        p[1] = a < b;
      end
      4'h1:    res = a & b;
      4'h2:    res = a | b;
      4'h3:    res = a ^ b;
      4'hD:    res = b;
      default: we = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic        we_t;
    logic [15:0] res_t;
    logic [4:0]  p_t;
    if (poke_en) m_regs[poke_addr] <= poke_data;
    if (reset) begin
      m_phase <= 0;
      m_psr   <= 5'h0;
`ifdef ALU_CTRL_ILLEGAL_EN
      m_illegal <= 1'b0;
`endif
    end else begin
      case (m_phase)
        0: if (instr_valid) begin
          m_instr <= instr;
          m_phase <= 1;
        end
        1: begin
          model_exec(m_instr, we_t, res_t, p_t);
          m_exp_we  <= we_t;
          m_exp_res <= res_t;
          m_exp_psr <= p_t;
          m_phase   <= 2;
        end
        default: begin
          if (m_exp_we) m_regs[m_instr[11:8]] <= m_exp_res;
          m_psr <= m_exp_psr;
`ifdef ALU_CTRL_ILLEGAL_EN
          if (undecoded(m_instr)) m_illegal <= 1'b1;
`endif
          m_phase <= 0;
        end
      endcase
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    logic exp_we;
    exp_we = (m_phase == 2) && m_exp_we && !reset;
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("instr_ready", 32'(instr_ready), 32'(m_phase == 0));
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      chk("rf_wr_addr", 32'(rf_wr_addr), 32'(m_instr[11:8]));
      chk("rf_wr_data", 32'(rf_wr_data), 32'(m_exp_res));
    end
    if (m_phase == 1) begin
      chk("rf_addr_a", 32'(rf_addr_a), 32'(m_instr[11:8]));
      chk("rf_addr_b", 32'(rf_addr_b), 32'(m_instr[3:0]));
    end
    chk("psr", 32'(psr), 32'(m_psr));
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("illegal", 32'(illegal), 32'(m_illegal));
`endif
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  // Presents an instruction until accepted; returns the cycle count at the accepting edge.
  task automatic issue(input logic [15:0] i, input bit keep, output int acc_cyc);
    logic got;
    got         = 1'b0;
    instr       = i;
    instr_valid = 1'b1;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      compare();
      got = instr_ready;
      @(posedge clk);
      cyc++;
      #1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: instr 0x%0h not accepted within 12 cycles", i);
    end
    acc_cyc = cyc;
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] i);
    int c;
    issue(i, 1'b0, c);
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1;
    step();
    step();
    reset = 1'b0;
    chk("reset_psr", 32'(psr), 32'h00);
    chk("reset_ready", 32'(instr_ready), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);

    poke(4'd1, 16'h7FFF);
    poke(4'd2, 16'h0001);
    poke(4'd4, 16'h0005);
    poke(4'd5, 16'h0005);

    run(16'h0152);  // ADD R1,R2
    chk("add_r1", 32'(rf[1]), 32'h8000);
    chk("add_psr", 32'(psr), 32'b00100);
    run(16'h93FF);  // SUBI R3,-1
    chk("subi_r3", 32'(rf[3]), 32'h0001);
    chk("subi_psr", 32'(psr), 32'b00001);
    run(16'h04B5);  // CMP R4,R5
    chk("cmp_r4", 32'(rf[4]), 32'h0005);
    chk("cmp_psr", 32'(psr), 32'b01001);

    issue(16'hD6F0, 1'b1, c0);  // MOVI R6,0xF0
    issue(16'h163C, 1'b0, c1);  // ANDI R6,0x3C held while busy
    chk("movi_r6", 32'(rf[6]), 32'h00F0);
    chk("accept_gap", 32'(c1 - c0), 32'd3);
    step();
    step();
    chk("andi_r6", 32'(rf[6]), 32'h0030);
    chk("logic_psr", 32'(psr), 32'b01001);

    poke(4'd7, 16'h1234);
    run(16'h0757);  // ADD R7,R7
    chk("add_same_reg", 32'(rf[7]), 32'h2468);
    chk("add_same_psr", 32'(psr), 32'b01000);
    run(16'h2280);  // ORI R2,0x80 (zero-extended)
    chk("ori_r2", 32'(rf[2]), 32'h0081);
    run(16'h52FE);  // ADDI R2,-2
    chk("addi_r2", 32'(rf[2]), 32'h007F);
    chk("addi_psr", 32'(psr), 32'b01001);
    run(16'h0236);  // XOR R2,R6
    chk("xor_r2", 32'(rf[2]), 32'h004F);
    run(16'h08D1);  // MOV R8,R1
    chk("mov_r8", 32'(rf[8]), 32'h8000);
    run(16'hB407);  // CMPI R4,7
    chk("cmpi_psr", 32'(psr), 32'b10011);
    run(16'h01B2);  // CMP R1,R2: signed less, unsigned greater
    chk("cmp_sign_psr", 32'(psr), 32'b10001);
    run(16'h0594);  // SUB R5,R4
    chk("sub_r5", 32'(rf[5]), 32'h0000);
    chk("sub_psr", 32'(psr), 32'b10000);

    run(16'h0170);  // undecoded ext
    chk("nop_r1", 32'(rf[1]), 32'h8000);
    chk("nop_psr", 32'(psr), 32'b10000);
    run(16'hF000);  // undecoded op
    chk("nopf_r0", 32'(rf[0]), 32'h0000);
    chk("nopf_psr", 32'(psr), 32'b10000);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("illegal_set", 32'(illegal), 32'h1);
    run(16'hD911);  // MOVI R9,0x11
    chk("illegal_held", 32'(illegal), 32'h1);
    chk("movi_r9", 32'(rf[9]), 32'h0011);
`endif

    // Reset during EXEC aborts the ADD.
    issue(16'h0152, 1'b0, c0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_exec_psr", 32'(psr), 32'h00);
    chk("abort_exec_ready", 32'(instr_ready), 32'h1);
    chk("abort_exec_r1", 32'(rf[1]), 32'h8000);
`ifdef ALU_CTRL_ILLEGAL_EN
    chk("illegal_cleared", 32'(illegal), 32'h0);
`endif
    step();

    // Reset during WB suppresses the write.
    issue(16'h0152, 1'b0, c0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_wb_r1", 32'(rf[1]), 32'h8000);
    chk("abort_wb_busy", 32'(busy), 32'h0);
    step();

    // Reset together with valid must not accept.
    instr       = 16'h0152;
    instr_valid = 1'b1;
    reset       = 1'b1;
    step();
    reset       = 1'b0;
    instr_valid = 1'b0;
    chk("reset_valid_busy", 32'(busy), 32'h0);
    step();
    step();
    chk("reset_valid_r1", 32'(rf[1]), 32'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
